// File: rtl/full_add.sv
// rtl/full_add.sv - one-bit full adder, the only arithmetic in serial_add
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // sum and majority carry of three input bits
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add.sv
// rtl/serial_add.sv - bit-serial N-bit adder, LSB first, one bit per clock
module serial_add #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
);

  // counter needs at least one bit so that N=1 still has a legal vector
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  sum_sh;
  logic [N-1:0]  sum_nx;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sum_r;
  logic          cout_r;
  logic          fa_s;
  logic          fa_c;

  full_add u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // next value of the sum shifter: new bit enters at the MSB, so after N bits
  // the first (LSB) result bit has arrived at position 0
  always_comb begin
    sum_nx        = sum_sh >> 1;
    sum_nx[N-1]   = fa_s;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // datapath: operand load, bit shifting, carry link and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nx;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          // results are published only when the last bit completes
          if (cnt == LAST) begin
            sum_r  <= sum_nx;
            cout_r <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add.sv
// tb/tb_serial_add.sv - self-checking bench for serial_add (N=8 and N=1)
module tb_serial_add;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;

  logic       p_in_valid, p_in_ready, p_cin, p_out_valid, p_out_ready, p_cout, p_busy;
  logic [0:0] p_a, p_b, p_sum;

  int n_cmp = 0;
  int n_bad = 0;
  int n_in  = 0;
  int n_out = 0;

  always #5 clk = ~clk;

  serial_add #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .cin(p_cin), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .sum(p_sum), .cout(p_cout), .busy(p_busy)
  );

  // transfer counters for the lost/duplicated check
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready)   n_in++;
    if (!rst && out_valid && out_ready) n_out++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present operands, wait for acceptance, then wait for out_valid;
  // lat counts rising edges after the accept edge
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                          input int pre, output int lat);
    int guard;
    repeat (pre) @(negedge clk);
    a = ta; b = tb2; cin = tc; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'(guard), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("done_timeout", 32'(lat), 8);
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] exp9;
    logic [1:0] exp2;
    logic [7:0] ra, rb;
    logic       rc;
    logic [7:0] hold_sum;
    int lat, in0, out0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    p_in_valid = 1'b0; p_out_ready = 1'b0; p_a = '0; p_b = '0; p_cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum_cout", {23'd0, cout, sum}, 0);

    // FF + 01: full wrap, N edges after the accept edge
    start_op(8'hFF, 8'h01, 1'b0, 0, lat);
    chk("lat_ff01", 32'(lat), 8);
    chk("res_ff01", {23'd0, cout, sum}, 32'(9'h100));
    finish_op(0);
    chk("idle_after_ff01", 32'(in_ready), 1);
    chk("hold_in_idle", {23'd0, cout, sum}, 32'(9'h100));

    start_op(8'h5A, 8'hA5, 1'b1, 1, lat);
    chk("res_5aa5", {23'd0, cout, sum}, 32'(9'h100));
    finish_op(2);

    start_op(8'h12, 8'h34, 1'b0, 0, lat);
    chk("lat_1234", 32'(lat), 8);
    chk("res_1234", {23'd0, cout, sum}, 32'(9'h046));
    finish_op(0);

    // backpressure: result and handshakes stay frozen, new operands ignored
    start_op(8'hC3, 8'h7E, 1'b1, 0, lat);
    exp9 = 9'h0C3 + 9'h07E + 9'h001;
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_res", {23'd0, cout, sum}, 32'(exp9));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
    chk("bp_release_busy", 32'(busy), 0);
    @(negedge clk);
    chk("bp_ignored_op", {29'd0, busy, cout, 1'b0} | 32'(sum != exp9[7:0]), 32'(exp9[8]) << 1);

    // reset after the third bit of a run
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_run_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("mid_rst_res", {23'd0, cout, sum}, 0);
    start_op(8'h0F, 8'h01, 1'b0, 0, lat);
    chk("res_0f01", {23'd0, cout, sum}, 32'(9'h010));
    finish_op(0);

    // N=1: 1+1+1 -> 3, one RUN cycle
    p_a = 1'b1; p_b = 1'b1; p_cin = 1'b1; p_in_valid = 1'b1;
    chk("n1_in_ready", 32'(p_in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    p_in_valid = 1'b0;
    chk("n1_run_busy", {30'd0, p_busy, p_out_valid}, 32'b10);
    @(negedge clk);
    chk("n1_done", 32'(p_out_valid), 1);
    exp2 = 2'd1 + 2'd1 + 2'd1;
    chk("n1_res", {30'd0, p_cout, p_sum}, 32'(exp2));
    p_out_ready = 1'b1;
    @(negedge clk);
    p_out_ready = 1'b0;
    chk("n1_idle", 32'(p_in_ready), 1);

    // random operands with random stalls on both handshakes
    in0 = n_in; out0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      start_op(ra, rb, rc, int'($urandom_range(0, 2)), lat);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      chk("rand_res", {23'd0, cout, sum}, 32'(exp9));
      if (i % 100 == 0) chk("rand_lat", 32'(lat), 8);
      finish_op(int'($urandom_range(0, 3)));
    end
    chk("rand_in_count", 32'(n_in - in0), 1000);
    chk("rand_out_count", 32'(n_out - out0), 1000);
    hold_sum = sum;
    chk("rand_final_hold", 32'(hold_sum), 32'(exp9[7:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
